// File: rtl/ide_port_arbiter.sv
// Round-robin arbiter for the shared IDE register/data port; sector data bursts are never split.
// Define ARB_TIMEOUT_EN to let an idle owner be forcibly revoked after IDLE_TIMEOUT cycles.
module ide_port_arbiter #(
  parameter int BURST_LEN    = 256,
  parameter int IDLE_TIMEOUT = 1023
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        a_req,
  output logic        a_gnt,
  input  logic [4:0]  a_addr,
  input  logic        a_rd,
  input  logic        a_wr,
  input  logic [15:0] a_wdata,
  output logic [15:0] a_rdata,
  output logic        a_rvalid,
  input  logic        b_req,
  output logic        b_gnt,
  input  logic [4:0]  b_addr,
  input  logic        b_rd,
  input  logic        b_wr,
  input  logic [15:0] b_wdata,
  output logic [15:0] b_rdata,
  output logic        b_rvalid,
  output logic [4:0]  ide_addr,
  output logic        ide_rd,
  output logic        ide_wr,
  output logic [15:0] ide_dout,
  input  logic [15:0] ide_din
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_OWN_A    = 2'd1,
    ST_OWN_B    = 2'd2,
    ST_HANDOVER = 2'd3
  } state_t;

  localparam logic [9:0] BURST_LEN_C = 10'(BURST_LEN);

  // Elaboration-only range guard; the block is empty and never instantiates anything.
  if ((BURST_LEN < 2) || (BURST_LEN > 512) || (IDLE_TIMEOUT < 1) || (IDLE_TIMEOUT > 65535)) begin : g_cfg_range_error
  end

  state_t      state_r, state_nxt_s;
  logic        last_b_r, last_b_nxt_s;
  logic [8:0]  burst_cnt_r, burst_nxt_s;
  logic        rd_from_b_r;
  logic        own_a_s, own_b_s, owner_req_s, other_req_s;
  logic [4:0]  own_addr_s;
  logic        own_rd_s, own_wr_s, strobe_s;
  logic [15:0] own_wdata_s;
  logic        timeout_s;

  function automatic state_t arbitrate(input logic req_a, input logic req_b, input logic last_b);
    if (req_a && req_b) begin
      return last_b ? ST_OWN_A : ST_OWN_B;
    end else if (req_a) begin
      return ST_OWN_A;
    end else if (req_b) begin
      return ST_OWN_B;
    end else begin
      return ST_IDLE;
    end
  endfunction

  // Owner strobe mux and burst counter advance; non-owner strobes never reach the port.
  always_comb begin
    own_a_s     = (state_r == ST_OWN_A);
    own_b_s     = (state_r == ST_OWN_B);
    own_addr_s  = 5'h00;
    own_rd_s    = 1'b0;
    own_wr_s    = 1'b0;
    own_wdata_s = 16'h0000;
    owner_req_s = 1'b0;
    other_req_s = 1'b0;
    if (own_a_s) begin
      own_addr_s  = a_addr;
      own_rd_s    = a_rd;
      own_wr_s    = a_wr;
      own_wdata_s = a_wdata;
      owner_req_s = a_req;
      other_req_s = b_req;
    end else if (own_b_s) begin
      own_addr_s  = b_addr;
      own_rd_s    = b_rd;
      own_wr_s    = b_wr;
      own_wdata_s = b_wdata;
      owner_req_s = b_req;
      other_req_s = a_req;
    end else begin
      own_addr_s  = 5'h00;
    end
    strobe_s    = own_rd_s | own_wr_s;
    burst_nxt_s = burst_cnt_r;
    if (strobe_s && (own_addr_s == 5'h00)) begin
      if (({1'b0, burst_cnt_r} + 10'd1) == BURST_LEN_C) begin
        burst_nxt_s = 9'd0;
      end else begin
        burst_nxt_s = burst_cnt_r + 9'd1;
      end
    end else begin
      burst_nxt_s = burst_cnt_r;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] IDLE_TIMEOUT_C = 16'(IDLE_TIMEOUT);

  logic [15:0] tmo_cnt_r;
  logic        tmo_inc_s;

  assign tmo_inc_s = (own_a_s | own_b_s) & ~strobe_s & other_req_s & (burst_cnt_r == 9'd0);
  assign timeout_s = tmo_inc_s & ((tmo_cnt_r + 16'd1) == IDLE_TIMEOUT_C);

  // Idle counter: restarts on any owner strobe or state change.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      tmo_cnt_r <= 16'd0;
    end else if (strobe_s || (state_nxt_s != state_r)) begin
      tmo_cnt_r <= 16'd0;
    end else if (tmo_inc_s) begin
      tmo_cnt_r <= tmo_cnt_r + 16'd1;
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state logic; HANDOVER arbitrates directly so it lasts exactly one cycle.
  always_comb begin
    state_nxt_s  = state_r;
    last_b_nxt_s = last_b_r;
    case (state_r)
      ST_IDLE, ST_HANDOVER: begin
        state_nxt_s = arbitrate(a_req, b_req, last_b_r);
      end
      ST_OWN_A: begin
        if ((!owner_req_s && (burst_nxt_s == 9'd0)) || timeout_s) begin
          state_nxt_s  = ST_HANDOVER;
          last_b_nxt_s = 1'b0;
        end else begin
          state_nxt_s  = ST_OWN_A;
        end
      end
      ST_OWN_B: begin
        if ((!owner_req_s && (burst_nxt_s == 9'd0)) || timeout_s) begin
          state_nxt_s  = ST_HANDOVER;
          last_b_nxt_s = 1'b1;
        end else begin
          state_nxt_s  = ST_OWN_B;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, grants, port strobes and read return, all registered.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      last_b_r    <= 1'b1;
      burst_cnt_r <= 9'd0;
      rd_from_b_r <= 1'b0;
      a_gnt       <= 1'b0;
      b_gnt       <= 1'b0;
      ide_addr    <= 5'h00;
      ide_rd      <= 1'b0;
      ide_wr      <= 1'b0;
      ide_dout    <= 16'h0000;
      a_rdata     <= 16'h0000;
      b_rdata     <= 16'h0000;
      a_rvalid    <= 1'b0;
      b_rvalid    <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      last_b_r    <= last_b_nxt_s;
      burst_cnt_r <= burst_nxt_s;
      a_gnt       <= (state_nxt_s == ST_OWN_A);
      b_gnt       <= (state_nxt_s == ST_OWN_B);
      ide_wr      <= own_wr_s;
      ide_rd      <= own_rd_s & ~own_wr_s;
      if (strobe_s) begin
        ide_addr    <= own_addr_s;
        rd_from_b_r <= own_b_s;
      end else begin
        ide_addr    <= ide_addr;
        rd_from_b_r <= rd_from_b_r;
      end
      if (own_wr_s) begin
        ide_dout <= own_wdata_s;
      end else begin
        ide_dout <= ide_dout;
      end
      a_rvalid <= ide_rd & ~rd_from_b_r;
      b_rvalid <= ide_rd & rd_from_b_r;
      if (ide_rd && !rd_from_b_r) begin
        a_rdata <= ide_din;
      end else begin
        a_rdata <= a_rdata;
      end
      if (ide_rd && rd_from_b_r) begin
        b_rdata <= ide_din;
      end else begin
        b_rdata <= b_rdata;
      end
    end
  end

endmodule

// File: tb/tb_ide_port_arbiter.sv
// Directed self-checking bench for ide_port_arbiter (IDLE_TIMEOUT = 8 for the timeout case).
module tb_ide_port_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        a_req = 1'b0, a_rd = 1'b0, a_wr = 1'b0;
  logic [4:0]  a_addr = 5'h00;
  logic [15:0] a_wdata = 16'h0000;
  logic        b_req = 1'b0, b_rd = 1'b0, b_wr = 1'b0;
  logic [4:0]  b_addr = 5'h00;
  logic [15:0] b_wdata = 16'h0000;
  logic [15:0] ide_din = 16'h1111;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid, ide_rd, ide_wr;
  logic [15:0] a_rdata, b_rdata, ide_dout;
  logic [4:0]  ide_addr;

  int          errs  = 0;
  int          n_chk = 0;
  logic [15:0] last_din = 16'h0000;

  ide_port_arbiter #(.BURST_LEN(256), .IDLE_TIMEOUT(8)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .a_req(a_req), .a_gnt(a_gnt), .a_addr(a_addr), .a_rd(a_rd), .a_wr(a_wr),
    .a_wdata(a_wdata), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_gnt(b_gnt), .b_addr(b_addr), .b_rd(b_rd), .b_wr(b_wr),
    .b_wdata(b_wdata), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .ide_addr(ide_addr), .ide_rd(ide_rd), .ide_wr(ide_wr),
    .ide_dout(ide_dout), .ide_din(ide_din)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ide_din changes just after each edge; last_din holds what the DUT saw at that edge.
  task automatic tick;
    last_din = ide_din;
    @(posedge clk_sys);
    #1;
    ide_din = last_din + 16'h1357;
  endtask

  task automatic clear_inputs;
    a_req = 1'b0; a_rd = 1'b0; a_wr = 1'b0; a_addr = 5'h00; a_wdata = 16'h0000;
    b_req = 1'b0; b_rd = 1'b0; b_wr = 1'b0; b_addr = 5'h00; b_wdata = 16'h0000;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_a_gnt"},    a_gnt,    0);
    check_val({tag, "_b_gnt"},    b_gnt,    0);
    check_val({tag, "_ide_rd"},   ide_rd,   0);
    check_val({tag, "_ide_wr"},   ide_wr,   0);
    check_val({tag, "_ide_addr"}, ide_addr, 0);
    check_val({tag, "_ide_dout"}, ide_dout, 0);
    check_val({tag, "_a_rdata"},  a_rdata,  0);
    check_val({tag, "_b_rdata"},  b_rdata,  0);
    check_val({tag, "_a_rvalid"}, a_rvalid, 0);
    check_val({tag, "_b_rvalid"}, b_rvalid, 0);
  endtask

  initial begin
    // Reset state and single-requester accesses
    do_reset();
    check_zero("rst");
    a_req = 1'b1;
    tick();
    check_val("a_gnt_lat", a_gnt, 1);
    tick();
    a_wr = 1'b1; a_addr = 5'h07; a_wdata = 16'h00EC;
    tick();
    a_wr = 1'b0;
    check_val("wr_ide_wr", ide_wr, 1);
    check_val("wr_ide_addr", ide_addr, 5'h07);
    check_val("wr_ide_dout", ide_dout, 16'h00EC);
    check_val("wr_ide_rd", ide_rd, 0);
    a_rd = 1'b1; a_addr = 5'h03;
    tick();
    a_rd = 1'b0;
    check_val("rd_ide_rd", ide_rd, 1);
    check_val("rd_ide_addr", ide_addr, 5'h03);
    check_val("rd_ide_wr", ide_wr, 0);
    a_rd = 1'b1; a_wr = 1'b1; a_addr = 5'h05; a_wdata = 16'h1234;
    tick();
    a_rd = 1'b0; a_wr = 1'b0;
    check_val("rd_a_rvalid", a_rvalid, 1);
    check_val("rd_a_rdata", a_rdata, last_din);
    check_val("rdwr_ide_wr", ide_wr, 1);
    check_val("rdwr_ide_rd", ide_rd, 0);
    check_val("rdwr_dout", ide_dout, 16'h1234);
    tick();
    check_val("rdwr_no_rvalid", a_rvalid, 0);
    a_req = 1'b0;
    tick();
    check_val("a_release", a_gnt, 0);
    tick();
    check_val("a_stay_idle", a_gnt, 0);

    // Tie after reset, handover, round-robin
    do_reset();
    a_req = 1'b1; b_req = 1'b1;
    tick();
    check_val("tie_a_gnt", a_gnt, 1);
    check_val("tie_b_gnt", b_gnt, 0);
    a_req = 1'b0;
    tick();
    check_val("ho_a_gnt", a_gnt, 0);
    check_val("ho_b_gnt", b_gnt, 0);
    tick();
    check_val("rr_b_gnt", b_gnt, 1);
    b_req = 1'b0;
    tick();
    check_val("ho2_b_gnt", b_gnt, 0);
    a_req = 1'b1; b_req = 1'b1;
    tick();
    check_val("rr2_a_gnt", a_gnt, 1);
    check_val("rr2_b_gnt", b_gnt, 0);

    // Full read burst by B; req drops after 100 reads but the burst completes
    do_reset();
    b_req = 1'b1;
    tick();
    check_val("burst_b_gnt", b_gnt, 1);
    a_req = 1'b1;
    for (int i = 0; i < 258; i++) begin
      if (i >= 2) begin
        check_val("burst_rvalid", b_rvalid, 1);
        check_val("burst_rdata", b_rdata, last_din);
      end
      if (i < 256) begin
        check_val("burst_hold", b_gnt, 1);
      end else if (i == 256) begin
        check_val("burst_end_b", b_gnt, 0);
        check_val("burst_end_a", a_gnt, 0);
      end else begin
        check_val("burst_next_a", a_gnt, 1);
      end
      b_rd = (i < 256); b_addr = 5'h00;
      if (i == 100) b_req = 1'b0;
      tick();
    end
    b_rd = 1'b0;
    check_val("burst_rvalid_off", b_rvalid, 0);

    // Non-owner write is dropped and leaves B's burst count alone
    do_reset();
    b_req = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      b_rd = 1'b1; b_addr = 5'h00;
      tick();
    end
    b_rd = 1'b0;
    a_wr = 1'b1; a_addr = 5'h00; a_wdata = 16'hBEEF;
    tick();
    a_wr = 1'b0;
    check_val("nonown_ide_wr", ide_wr, 0);
    check_val("nonown_dout", ide_dout, 0);
    check_val("nonown_b_gnt", b_gnt, 1);
    check_val("nonown_a_gnt", a_gnt, 0);
    b_req = 1'b0;
    for (int j = 0; j < 254; j++) begin
      if (j < 253) begin
        check_val("nonown_hold", b_gnt, 1);
      end else begin
        check_val("nonown_end", b_gnt, 0);
      end
      b_rd = (j < 253); b_addr = 5'h00;
      tick();
    end
    b_rd = 1'b0;

    // Idle owner with a waiting requester
    do_reset();
    a_req = 1'b1; b_req = 1'b1;
    tick();
    check_val("tmo_a_gnt0", a_gnt, 1);
    for (int k = 1; k <= 12; k++) begin
      tick();
`ifdef ARB_TIMEOUT_EN
      check_val("tmo_a_gnt", a_gnt, (k < 8) ? 1 : 0);
      check_val("tmo_b_gnt", b_gnt, (k >= 9) ? 1 : 0);
`else
      check_val("tmo_a_gnt", a_gnt, 1);
      check_val("tmo_b_gnt", b_gnt, 0);
`endif
    end

    // Reset asserted mid-burst at word 40
    do_reset();
    a_req = 1'b1;
    tick();
    for (int w = 0; w < 40; w++) begin
      a_wr = 1'b1; a_addr = 5'h00; a_wdata = 16'(w + 16'h0100);
      tick();
    end
    check_val("mid_a_gnt", a_gnt, 1);
    #2 reset = 1'b1;
    #1;
    check_zero("async_rst");
    clear_inputs();
    tick();
    tick();
    check_zero("held_rst");
    reset = 1'b0;
    tick();
    check_zero("post_rst");
    a_req = 1'b1; b_req = 1'b1;
    tick();
    check_val("post_tie_a", a_gnt, 1);
    check_val("post_tie_b", b_gnt, 0);
    a_req = 1'b0;
    tick();
    check_val("post_rel_a", a_gnt, 0);
    tick();
    check_val("post_b_gnt", b_gnt, 1);

    $display("Result: errors=%0d of %0d checks", errs, n_chk);
    $finish;
  end

endmodule
